// File: rtl/multi_ctrl_pkg.sv
// Shared definitions for the multi_ctrl pipe family: lane count, mask encoding
// and the helper that computes which lanes remain pending after a handshake cycle.
package multi_ctrl_pkg;

    localparam int LANES = 2;

    typedef logic [LANES-1:0] lane_mask_t;

    localparam lane_mask_t MASK_NONE = 2'b00;
    localparam lane_mask_t MASK_L0   = 2'b01;
    localparam lane_mask_t MASK_L1   = 2'b10;
    localparam lane_mask_t MASK_ALL  = 2'b11;

    // Lanes still owed the held beat once this cycle's readies are applied.
    function automatic lane_mask_t lanes_left(input lane_mask_t pend, input lane_mask_t rdy);
        return pend & ~rdy;
    endfunction

endpackage

// File: rtl/multi_ctrl_fork_pipe.sv
// Purpose: one-entry fork that delivers each master beat to a masked subset of two lanes.
// Latency: 1 cycle from acceptance to b_valid_out; one beat per cycle when all masked lanes are ready.
// Backpressure: f_ready_out is high when empty or when every pending lane accepts this cycle.
module multi_ctrl_fork_pipe
    import multi_ctrl_pkg::*;
#(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_valid_in,
    input  logic [DATA_W-1:0] f_data_in,
    input  logic [LANES-1:0]  f_mask_in,
    output logic              f_ready_out,
    output logic [LANES-1:0]  b_valid_out,
    output logic [DATA_W-1:0] b_data_out,
    input  logic [LANES-1:0]  b_ready_in,
    output logic              busy_out
);

    lane_mask_t        pend;
    lane_mask_t        remaining;
    logic [DATA_W-1:0] hold_data;
    logic              occupied;
    logic              complete;
    logic              accept;

    assign occupied  = |pend;
    assign remaining = lanes_left(pend, b_ready_in);
    assign complete  = occupied && (remaining == MASK_NONE);

    // No combinational path from f_valid_in to f_ready_out.
    assign f_ready_out = ~occupied | complete;
    assign accept      = f_valid_in & f_ready_out;

    assign b_valid_out = pend;
    assign b_data_out  = hold_data;
    assign busy_out    = occupied;

    // hold_data only reloads on accept, which implies the previous beat is fully delivered,
    // so the payload stays stable while any lane is still pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= MASK_NONE;
            hold_data <= '0;
        end else if (accept && (f_mask_in != MASK_NONE)) begin
            pend      <= f_mask_in;
            hold_data <= f_data_in;
        end else begin
            // Zero-mask beats fall through here and are dropped.
            pend <= remaining;
        end
    end

endmodule

// File: tb/tb_multi_ctrl_fork_pipe.sv
// Scoreboarded bench for multi_ctrl_fork_pipe: per-lane expected queues filled on
// master handshakes and drained on lane handshakes, plus per-scenario direct checks.
module tb_multi_ctrl_fork_pipe;

    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          f_valid_in;
    logic [DW-1:0] f_data_in;
    logic [1:0]    f_mask_in;
    logic          f_ready_out;
    logic [1:0]    b_valid_out;
    logic [DW-1:0] b_data_out;
    logic [1:0]    b_ready_in;
    logic          busy_out;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    multi_ctrl_fork_pipe #(.DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_valid_in  (f_valid_in),
        .f_data_in   (f_data_in),
        .f_mask_in   (f_mask_in),
        .f_ready_out (f_ready_out),
        .b_valid_out (b_valid_out),
        .b_data_out  (b_data_out),
        .b_ready_in  (b_ready_in),
        .busy_out    (busy_out)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        f_valid_in = 1'b0;
        f_data_in  = '0;
        f_mask_in  = 2'b00;
        b_ready_in = 2'b00;
        #2;
        checks++;
        if (b_valid_out !== 2'b00 || busy_out !== 1'b0 || f_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b busy=%b ready=%b required valid=00 busy=0 ready=1",
                     b_valid_out, busy_out, f_ready_out);
        end
        checks++;
        if (b_data_out !== '0) begin
            errors++;
            $display("FAIL reset_data got %h required 0", b_data_out);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_beat();
        f_valid_in = 1'b1;
        f_data_in  = 'hA5;
        f_mask_in  = 2'b11;
        b_ready_in = 2'b11;
        @(negedge clk);
        checks++;
        if (f_ready_out !== 1'b1 || b_valid_out !== 2'b00) begin
            errors++;
            $display("FAIL single_accept got ready=%b valid=%b required ready=1 valid=00", f_ready_out, b_valid_out);
        end
        next_cycle();
        f_valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (b_valid_out !== 2'b11 || b_data_out !== DW'('hA5) || f_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL single_out got valid=%b data=%h ready=%b required valid=11 data=a5 ready=1",
                     b_valid_out, b_data_out, f_ready_out);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (b_valid_out !== 2'b00 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL single_done got valid=%b busy=%b required valid=00 busy=0", b_valid_out, busy_out);
        end
        next_cycle();
    endtask

    task automatic test_partial_accept();
        f_valid_in = 1'b1;
        f_data_in  = 'h5A;
        f_mask_in  = 2'b11;
        b_ready_in = 2'b01;
        next_cycle();
        f_valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (b_valid_out !== 2'b11 || f_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL partial_c1 got valid=%b ready=%b required valid=11 ready=0", b_valid_out, f_ready_out);
        end
        next_cycle();
        b_ready_in = 2'b10;
        @(negedge clk);
        checks++;
        if (b_valid_out !== 2'b10 || f_ready_out !== 1'b1 || b_data_out !== DW'('h5A)) begin
            errors++;
            $display("FAIL partial_c2 got valid=%b ready=%b data=%h required valid=10 ready=1 data=5a",
                     b_valid_out, f_ready_out, b_data_out);
        end
        next_cycle();
        b_ready_in = 2'b11;
        @(negedge clk);
        checks++;
        if (b_valid_out !== 2'b00) begin
            errors++;
            $display("FAIL partial_c3 got valid=%b required 00", b_valid_out);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        b_ready_in = 2'b11;
        f_mask_in  = 2'b11;
        for (int k = 0; k <= 8; k++) begin
            f_valid_in = (k < 8);
            f_data_in  = DW'(k + 1);
            @(negedge clk);
            if (k < 8) begin
                checks++;
                if (f_ready_out !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready k=%0d got %b required 1", k, f_ready_out);
                end
            end
            if (k >= 1) begin
                checks++;
                if (b_valid_out !== 2'b11 || b_data_out !== DW'(k)) begin
                    errors++;
                    $display("FAIL b2b_out k=%0d got valid=%b data=%0d required valid=11 data=%0d",
                             k, b_valid_out, b_data_out, k);
                end
            end
            next_cycle();
        end
        f_valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (b_valid_out !== 2'b00) begin
            errors++;
            $display("FAIL b2b_tail got valid=%b required 00", b_valid_out);
        end
        next_cycle();
    endtask

    task automatic test_zero_mask();
        f_valid_in = 1'b1;
        f_data_in  = 'h33;
        f_mask_in  = 2'b00;
        b_ready_in = 2'b11;
        @(negedge clk);
        checks++;
        if (f_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready got %b required 1", f_ready_out);
        end
        next_cycle();
        f_valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (b_valid_out !== 2'b00 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL zero_out got valid=%b busy=%b required valid=00 busy=0", b_valid_out, busy_out);
        end
        next_cycle();
    endtask

    task automatic test_lane1_stall();
        f_valid_in = 1'b1;
        f_data_in  = 'hC3;
        f_mask_in  = 2'b10;
        b_ready_in = 2'b01;
        next_cycle();
        // A competing beat is offered while stalled; it must not be taken.
        f_data_in = 'hEE;
        f_mask_in = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (b_valid_out !== 2'b10 || b_data_out !== DW'('hC3) || f_ready_out !== 1'b0) begin
                errors++;
                $display("FAIL stall_c%0d got valid=%b data=%h ready=%b required valid=10 data=c3 ready=0",
                         c, b_valid_out, b_data_out, f_ready_out);
            end
            next_cycle();
        end
        f_valid_in = 1'b0;
        b_ready_in = 2'b10;
        @(negedge clk);
        checks++;
        if (f_ready_out !== 1'b1 || b_valid_out !== 2'b10) begin
            errors++;
            $display("FAIL stall_release got ready=%b valid=%b required ready=1 valid=10", f_ready_out, b_valid_out);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (b_valid_out !== 2'b00) begin
            errors++;
            $display("FAIL stall_done got valid=%b required 00", b_valid_out);
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        f_valid_in = 1'b1;
        f_data_in  = 'h77;
        f_mask_in  = 2'b10;
        b_ready_in = 2'b00;
        next_cycle();
        f_valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (b_valid_out !== 2'b10 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre got valid=%b busy=%b required valid=10 busy=1", b_valid_out, busy_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_valid_out !== 2'b00 || busy_out !== 1'b0 || f_ready_out !== 1'b1 || b_data_out !== '0) begin
            errors++;
            $display("FAIL arst_now got valid=%b busy=%b ready=%b data=%h required valid=00 busy=0 ready=1 data=0",
                     b_valid_out, busy_out, f_ready_out, b_data_out);
        end
        q0.delete();
        q1.delete();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if (b_valid_out !== 2'b00) begin
            errors++;
            $display("FAIL arst_post got valid=%b required 00", b_valid_out);
        end
        next_cycle();
    endtask

    task automatic test_drained();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got lane0=%0d lane1=%0d outstanding required 0", q0.size(), q1.size());
        end
    endtask

    initial begin
        fork
            forever begin
                logic [DW-1:0] exp;
                @(negedge clk);
                if (rst_n) begin
                    if (b_valid_out[0] && b_ready_in[0]) begin
                        checks++;
                        if (q0.size() == 0) begin
                            errors++;
                            $display("FAIL lane0_extra got %h required no beat", b_data_out);
                        end else begin
                            exp = q0.pop_front();
                            if (b_data_out !== exp) begin
                                errors++;
                                $display("FAIL lane0_data got %h required %h", b_data_out, exp);
                            end
                        end
                    end
                    if (b_valid_out[1] && b_ready_in[1]) begin
                        checks++;
                        if (q1.size() == 0) begin
                            errors++;
                            $display("FAIL lane1_extra got %h required no beat", b_data_out);
                        end else begin
                            exp = q1.pop_front();
                            if (b_data_out !== exp) begin
                                errors++;
                                $display("FAIL lane1_data got %h required %h", b_data_out, exp);
                            end
                        end
                    end
                    if (f_valid_in && f_ready_out) begin
                        if (f_mask_in[0]) q0.push_back(f_data_in);
                        if (f_mask_in[1]) q1.push_back(f_data_in);
                    end
                end
            end
        join_none

        test_reset();
        test_single_beat();
        test_partial_accept();
        test_back_to_back();
        test_zero_mask();
        test_lane1_stall();
        test_drained();
        test_async_reset();
        test_drained();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
